// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one binary-weighted stage (16,8,4,2,1) per clock,
// fixed five-cycle SHIFT phase, then a one-cycle DONE pulse with a registered result.
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [4:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [2:0]       stage_q, stage_d;
    logic [4:0]       ctrl_q, ctrl_d;
    op_e              op_q, op_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [4:0]         shift_amt;
    logic [2*WIDTH-1:0] sra_ext;
    logic [WIDTH-1:0]   stage_val;

    // The control word is consumed MSB-first, so ctrl_q[4] always holds the bit
    // belonging to the stage currently being processed.
    always_comb begin
        shift_amt = 5'd1 << stage_q;
        sra_ext   = {{WIDTH{sign_q}}, work_q} >> shift_amt;
        stage_val = work_q;
        if (ctrl_q[4]) begin
            case (op_q)
                OP_SRL:  stage_val = work_q >> shift_amt;
                OP_SRA:  stage_val = sra_ext[WIDTH-1:0];
                default: stage_val = work_q << shift_amt;
            endcase
        end
    end

    // NOTE: every output and next-state is defaulted first so no path through
    // the case statement can leave a latch behind.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        ctrl_d   = ctrl_q;
        op_d     = op_q;
        sign_d   = sign_q;
        work_d   = work_q;
        result_d = result_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (start) begin
                    work_d  = data;
                    ctrl_d  = control;
                    op_d    = op_e'(op);
                    sign_d  = data[WIDTH-1];
                    stage_d = 3'd4;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                work_d  = stage_val;
                ctrl_d  = {ctrl_q[3:0], 1'b0};
                stage_d = stage_q - 3'd1;
                if (stage_q == 3'd0) begin
                    result_d = stage_val;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and wins over start on the same edge, so a
    // request presented together with reset is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            stage_q  <= 3'd0;
            ctrl_q   <= 5'd0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            ctrl_q   <= ctrl_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            work_q   <= work_d;
            result_q <= result_d;
        end
    end

    assign dataOut = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus 1000
// randomized operations compared against an arithmetic shift model.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  control;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    int n_checks;
    int n_pass;

    shift_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data    (data),
        .control (control),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the whole shift done in one step from the operation's definition.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                          input logic [4:0] c);
        case (o)
            2'b01:   model = d >> c;
            2'b10:   model = 32'($signed(d) >>> c);
            default: model = d << c;
        endcase
    endfunction

    // Present a request at the current negedge; returns at the next negedge
    // (first SHIFT cycle) with the inputs scrambled.
    task automatic start_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] c);
        start   = 1'b1;
        op      = o;
        data    = d;
        control = c;
        @(negedge clk);
        start   = 1'b0;
        op      = 2'($urandom);
        data    = $urandom;
        control = 5'($urandom);
    endtask

    // Counts negedges until done is seen (bounded), and how many of them had busy.
    task automatic wait_done(output int cyc, output int busy_cnt, output bit got);
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        got = done;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        op    = 2'b00;
        data  = 32'hFFFF_FFFF;
        control = 5'd1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 32'h0)
            $display("FAIL reset_state busy=%b done=%b dataOut=%h required 0 0 00000000", busy, done, dataOut);
        else n_pass++;
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL start_during_reset busy=%b done=%b required 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_directed;
        logic [1:0]  ops  [5] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11};
        logic [31:0] ds   [5] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h1234_5678};
        logic [4:0]  cs   [5] = '{5'd16, 5'd31, 5'd31, 5'd0, 5'd4};
        logic [31:0] exps [5] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678, 32'h2345_6780};
        int cyc, bc;
        bit got;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_op(ops[i], ds[i], cs[i]);
            wait_done(cyc, bc, got);
            n_checks++;
            if (!got || cyc !== 5 || bc !== 5)
                $display("FAIL directed_latency[%0d] done=%b cycles=%0d busy_cycles=%0d required 1 5 5", i, got, cyc, bc);
            else n_pass++;
            n_checks++;
            if (dataOut !== exps[i])
                $display("FAIL directed_result[%0d] dataOut=%h required %h", i, dataOut, exps[i]);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || dataOut !== exps[i])
                $display("FAIL directed_after[%0d] done=%b busy=%b dataOut=%h required 0 0 %h", i, done, busy, dataOut, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        bit got;
        @(negedge clk);
        start_op(2'b00, 32'h1, 5'd4);
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b10;
        data    = 32'hF000_0000;
        control = 5'd1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(cyc, bc, got);
        n_checks++;
        if (!got || cyc + 2 !== 5)
            $display("FAIL ignore_mid_shift_latency done=%b cycles=%0d required 1 5", got, cyc + 2);
        else n_pass++;
        n_checks++;
        if (dataOut !== 32'h0000_0010)
            $display("FAIL ignore_mid_shift_result dataOut=%h required 00000010", dataOut);
        else n_pass++;
        start_op(2'b01, 32'h0000_0100, 5'd8);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || dataOut !== 32'h0000_0010)
            $display("FAIL b2b_accept busy=%b done=%b dataOut=%h required 1 0 00000010", busy, done, dataOut);
        else n_pass++;
        wait_done(cyc, bc, got);
        n_checks++;
        if (!got || cyc !== 5 || dataOut !== 32'h0000_0001)
            $display("FAIL b2b_second done=%b cycles=%0d dataOut=%h required 1 5 00000001", got, cyc, dataOut);
        else n_pass++;
    endtask

    task automatic test_reset_mid_shift;
        int pulses;
        @(negedge clk);
        @(negedge clk);
        start_op(2'b00, 32'hA5A5_A5A5, 5'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 32'h0)
            $display("FAIL reset_mid_shift busy=%b done=%b dataOut=%h required 0 0 00000000", busy, done, dataOut);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || dataOut !== 32'h0)
            $display("FAIL reset_no_late_done activity=%0d dataOut=%h required 0 00000000", pulses, dataOut);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] d, exp_v, prev_exp;
        logic [4:0]  c;
        bit b2b, got;
        int cyc, bc;
        b2b = 1'b0;
        prev_exp = dataOut;
        for (int i = 0; i < 1000; i++) begin
            if (!b2b) @(negedge clk);
            o = 2'($urandom);
            d = $urandom;
            c = 5'($urandom);
            exp_v = model(o, d, c);
            start_op(o, d, c);
            n_checks++;
            if (busy !== 1'b1 || dataOut !== prev_exp)
                $display("FAIL random_accept[%0d] busy=%b dataOut=%h required 1 %h", i, busy, dataOut, prev_exp);
            else n_pass++;
            wait_done(cyc, bc, got);
            n_checks++;
            if (!got || cyc !== 5 || bc !== 5)
                $display("FAIL random_latency[%0d] done=%b cycles=%0d busy_cycles=%0d required 1 5 5", i, got, cyc, bc);
            else n_pass++;
            n_checks++;
            if (dataOut !== exp_v)
                $display("FAIL random_result[%0d] op=%b data=%h ctl=%0d dataOut=%h required %h", i, o, d, c, dataOut, exp_v);
            else n_pass++;
            prev_exp = exp_v;
            b2b = ($urandom_range(3) == 0);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        data     = 32'h0;
        control  = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
